cla_pipe_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor built from per-bit g/p cells.

---
 rtl/cla_pipe_adder_if.sv | 29 ++
 rtl/cla_pipe_adder.sv | 132 +++++++++++++
 tb/tb_cla_pipe_adder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_adder_if.sv
// Handshake and payload bundle for the pipelined CLA adder/subtractor.
// The slave side is the adder; the master side is the producer/consumer driving it.
interface cla_pipe_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;
   logic             g_out;
   logic             p_out;

   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf, g_out, p_out
   );

   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, sum, c_out, ovf, g_out, p_out
   );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 holds per-bit and per-group g/p terms; stage 2 resolves carries and the sum.
module cla_pipe_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned GROUP = 4
) (
   input logic             clk,
   input logic             rst_n,
   cla_pipe_adder_if.slave bus
);
   localparam int unsigned NG = WIDTH / GROUP;

   // Operand conditioning and group generate/propagate
   logic [WIDTH-1:0] b_eff, g_bit, p_bit;
   logic             cin_eff;
   logic [NG-1:0]    grp_g, grp_p;

   always_comb begin
      logic gk, pk;
      b_eff   = bus.sub ? ~bus.b : bus.b;
      cin_eff = bus.sub | bus.c_in;
      g_bit   = bus.a & b_eff;
      p_bit   = bus.a ^ b_eff;
      grp_g   = '0;
      grp_p   = '0;
      for (int k = 0; k < NG; k++) begin
         gk = 1'b0;
         pk = 1'b1;
         for (int j = 0; j < GROUP; j++) begin
            gk = g_bit[k*GROUP+j] | (p_bit[k*GROUP+j] & gk);
            pk = pk & p_bit[k*GROUP+j];
         end
         grp_g[k] = gk;
         grp_p[k] = pk;
      end
   end

   // Handshake
   logic s1_valid_q, s2_valid_q;
   logic s1_en, s2_en;

   always_comb begin
      s2_en        = !s2_valid_q | bus.out_ready;
      s1_en        = !s1_valid_q | s2_en;
      bus.in_ready = s1_en;
   end

   // Stage 1 registers
   logic [WIDTH-1:0] s1_g_q, s1_p_q;
   logic [NG-1:0]    s1_gg_q, s1_gp_q;
   logic             s1_cin_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_g_q     <= '0;
         s1_p_q     <= '0;
         s1_gg_q    <= '0;
         s1_gp_q    <= '0;
         s1_cin_q   <= 1'b0;
      end else if (s1_en) begin
         s1_valid_q <= bus.in_valid;
         // Bubbles leave the payload untouched
         if (bus.in_valid) begin
            s1_g_q   <= g_bit;
            s1_p_q   <= p_bit;
            s1_gg_q  <= grp_g;
            s1_gp_q  <= grp_p;
            s1_cin_q <= cin_eff;
         end
      end
   end

   // Group carries, intra-group carries and word-level flags
   logic [WIDTH-1:0] bit_c;
   logic [WIDTH-1:0] sum_d;
   logic             c_out_d, ovf_d, g_out_d, p_out_d;

   always_comb begin
      logic cg, cb, wg;
      bit_c = '0;
      cg    = s1_cin_q;
      wg    = 1'b0;
      for (int k = 0; k < NG; k++) begin
         cb = cg;
         for (int j = 0; j < GROUP; j++) begin
            bit_c[k*GROUP+j] = cb;
            cb = s1_g_q[k*GROUP+j] | (s1_p_q[k*GROUP+j] & cb);
         end
         cg = s1_gg_q[k] | (s1_gp_q[k] & cg);
         wg = s1_gg_q[k] | (s1_gp_q[k] & wg);
      end
      sum_d   = s1_p_q ^ bit_c;
      c_out_d = cg;
      ovf_d   = bit_c[WIDTH-1] ^ cg;
      g_out_d = wg;
      p_out_d = &s1_gp_q;
   end

   // Stage 2 registers
   logic [WIDTH-1:0] sum_q;
   logic             c_out_q, ovf_q, g_out_q, p_out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         sum_q      <= '0;
         c_out_q    <= 1'b0;
         ovf_q      <= 1'b0;
         g_out_q    <= 1'b0;
         p_out_q    <= 1'b0;
      end else if (s2_en) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            g_out_q <= g_out_d;
            p_out_q <= p_out_d;
         end
      end
   end

   always_comb begin
      bus.out_valid = s2_valid_q;
      bus.sum       = sum_q;
      bus.c_out     = c_out_q;
      bus.ovf       = ovf_q;
      bus.g_out     = g_out_q;
      bus.p_out     = p_out_q;
   end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: expected results are queued on acceptance and
// compared by a monitor as each result leaves the pipeline.
module tb_cla_pipe_adder;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   outs     = 0;
   int   outs_mark;
   bit   done;
   logic [19:0] sb[$];

   cla_pipe_adder_if #(.WIDTH(16)) bus ();

   cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference packed as {c_out, ovf, g_out, p_out, sum}
   function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
      logic [15:0] bp;
      logic        ce;
      logic [16:0] full, gen;
      logic [15:0] low;
      bp   = sub ? ~b : b;
      ce   = sub ? 1'b1 : cin;
      full = {1'b0, a} + {1'b0, bp} + {16'b0, ce};
      gen  = {1'b0, a} + {1'b0, bp};
      low  = {1'b0, a[14:0]} + {1'b0, bp[14:0]} + {15'b0, ce};
      return {full[16], low[15] ^ full[16], gen[16], &(a ^ bp), full[15:0]};
   endfunction

   // Monitor: pop before push so a simultaneous in/out pair matches the older entry
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            outs++;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got 0x%0h expected none", bus.sum);
            end else begin
               check("result", {12'b0, bus.c_out, bus.ovf, bus.g_out, bus.p_out, bus.sum},
                     {12'b0, sb.pop_front()});
            end
         end
         if (bus.in_valid && bus.in_ready)
            sb.push_back(model(bus.a, bus.b, bus.c_in, bus.sub));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an operation and hold it until the adder takes it (bounded)
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub);
      int   n = 0;
      logic acc;
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.c_in     = cin;
      bus.sub      = sub;
      do begin
         @(negedge clk);
         acc = bus.in_valid & bus.in_ready;
         tick();
         n++;
      end while (!acc && n < 100);
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: got no acceptance expected acceptance within 100 cycles");
      end
   endtask

   task automatic hand_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] esum,
                          input logic ec, input logic eo, input logic eg, input logic ep);
      send(a, b, cin, sub);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check({name, "_early"}, {31'b0, bus.out_valid}, 32'd0);
      @(negedge clk);
      check({name, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
      check({name, "_sum"}, {16'b0, bus.sum}, {16'b0, esum});
      check({name, "_flags"}, {28'b0, bus.c_out, bus.ovf, bus.g_out, bus.p_out},
            {28'b0, ec, eo, eg, ep});
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.c_in      = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;
      #12;
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_sum", {16'b0, bus.sum}, 32'd0);
      check("rst_flags", {28'b0, bus.c_out, bus.ovf, bus.g_out, bus.p_out}, 32'd0);
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      rst_n = 1'b1;
      tick();

      // Directed arithmetic with hand-computed results
      hand_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 0, 0, 0, 0);
      hand_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1, 0, 1, 0);
      hand_op("add_cin",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1, 0, 0, 1);
      hand_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 0, 1, 0, 0);
      hand_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 0, 0, 0, 0);
      hand_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1, 1, 1, 0);

      // Backpressure fills both stages, then drains in order
      outs_mark = outs;
      send(16'h0001, 16'h0002, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      send(16'h0010, 16'h0020, 1'b0, 1'b0);
      fork
         begin
            send(16'h0100, 16'h0200, 1'b0, 1'b0);
            send(16'h1000, 16'h2000, 1'b1, 1'b0);
            send(16'h0009, 16'h0003, 1'b0, 1'b1);
            bus.in_valid = 1'b0;
         end
         begin
            repeat (3) begin
               @(negedge clk);
               check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
               check("stall_sum", {16'b0, bus.sum}, 32'h0003);
            end
            tick();
            bus.out_ready = 1'b1;
         end
      join
      repeat (4) tick();
      check("stall_outputs", outs - outs_mark, 32'd5);
      check("stall_drained", sb.size(), 32'd0);

      // Output backpressure toggling every cycle
      outs_mark = outs;
      done      = 1'b0;
      fork
         begin
            for (int i = 1; i <= 10; i++) begin
               logic [15:0] va, vb;
               logic [3:0]  iv;
               iv = 4'(i);
               va = 16'(i * 16'h1357);
               vb = 16'h F0F0 ^ 16'(i * 16'h0421);
               send(va, vb, iv[0], iv[1]);
            end
            bus.in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               tick();
               bus.out_ready = ~bus.out_ready;
            end
         end
      join
      bus.out_ready = 1'b1;
      repeat (4) tick();
      check("toggle_outputs", outs - outs_mark, 32'd10);
      check("toggle_drained", sb.size(), 32'd0);

      // Asynchronous reset with both stages occupied
      bus.out_ready = 1'b0;
      send(16'hAAAA, 16'h1111, 1'b0, 1'b0);
      send(16'h5555, 16'h2222, 1'b1, 1'b0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("full_out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("arst_sum", {16'b0, bus.sum}, 32'd0);
      sb.delete();
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_idle", {31'b0, bus.out_valid}, 32'd0);
      end
      tick();
      send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_early", {31'b0, bus.out_valid}, 32'd0);
      @(negedge clk);
      check("post_rst_valid", {31'b0, bus.out_valid}, 32'd1);
      check("post_rst_sum", {16'b0, bus.sum}, 32'h1000);
      repeat (3) tick();
      check("final_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
